ecall_service_unit: RTL and testbench
=====================================

ECALL_SERVICE_UNIT -- requirements
Module: ecall_service_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 8, console byte FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, width of delivered-byte counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  ECALL request presented by pipeline controller.
REQ-006 SHALL have port req_a0  input  64  service code (0 = halt, 1 = putchar).
REQ-007 SHALL have port req_a1  input  64  service argument; bits [7:0] = character.
REQ-008 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-009 SHALL have port con_valid  output  1  console byte available.
REQ-010 SHALL have port con_data  output  8  console byte (FIFO head).
REQ-011 SHALL have port con_ready  input  1  console sink accepts byte.
REQ-012 SHALL have port halt  output  1  program finished, all output delivered; sticky.
REQ-013 SHALL have port err  output  1  unsupported service code seen; sticky.
REQ-014 SHALL have port fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 SHALL have port tx_count  output  CNT_W  bytes delivered on console, saturating.

Function
REQ-016 SHALL implement FSM states RUN, DRAIN, HALTED, ERROR; reset state RUN.
REQ-017 SHALL drive req_ready = (state==RUN) && (fifo_count < DEPTH), combinationally.
REQ-018 SHALL treat a request as accepted only when req_valid && req_ready at a rising edge.
REQ-019 SHALL, on accepted a0==1, push a1[7:0] into FIFO; upper a1 bits ignored; state stays RUN.
REQ-020 SHALL, on accepted a0==0, enter DRAIN; no FIFO push.
REQ-021 SHALL, on accepted a0 not in {0,1}, enter ERROR and set err; no FIFO push.
REQ-022 SHALL compare all 64 bits of req_a0 (e.g. 64'h1_0000_0001 is unsupported).
REQ-023 SHALL be first-word fall-through: con_valid = (fifo_count != 0), con_data = head entry; byte pushed at edge N visible at cycle N+1.
REQ-024 SHALL pop head on con_valid && con_ready; con_data held stable while con_valid && !con_ready.
REQ-025 SHALL keep fifo_count unchanged on simultaneous push and pop; read/write pointers wrap modulo DEPTH.
REQ-026 SHALL never push when full (guaranteed by REQ-017) and never pop when empty.
REQ-027 SHALL increment tx_count once per pop, saturating at all-ones.
REQ-028 SHALL, in DRAIN, continue popping; transition DRAIN->HALTED at the edge where fifo_count==0 is observed.
REQ-029 SHALL assert halt iff state==HALTED; HALTED and ERROR are terminal until rst.
REQ-030 SHALL continue draining FIFO in ERROR and HALTED (HALTED is entered only with empty FIFO).
REQ-031 SHALL ignore req_valid entirely while req_ready is low (no state or FIFO effect).

Reset
REQ-032 SHALL, while rst high, asynchronously force: state RUN, FIFO empty, pointers 0, fifo_count 0, tx_count 0, halt 0, err 0, con_valid 0.
REQ-033 SHALL, on rst mid-operation, discard buffered bytes; con_data value undefined while con_valid 0.
REQ-034 SHALL resume normal acceptance on the first rising edge after rst deasserts.

Verification
REQ-035 SHALL cover: putchar a0=1,a1=0x41 with con_ready=1 -> con_valid=1, con_data=0x41 one cycle later, tx_count=1 after pop.
REQ-036 SHALL cover: con_ready=0, 9 putchars of 0x30..0x38 with DEPTH=8 -> first 8 accepted, req_ready=0 at fifo_count=8; 9th accepted after one pop; output order 0x30..0x38.
REQ-037 SHALL cover: 3 chars buffered, con_ready=0, then halt a0=0 -> halt stays 0, req_ready=0; raise con_ready -> 3 bytes delivered, halt=1 on the cycle after FIFO empties, tx_count=3.
REQ-038 SHALL cover: halt request with empty FIFO -> DRAIN next cycle, halt=1 two cycles after acceptance; further req_valid ignored.
REQ-039 SHALL cover: a0=2 -> err=1 next cycle, req_ready=0, halt=0; buffered bytes still drained.
REQ-040 SHALL cover: rst pulse asynchronously mid-drain with 4 bytes buffered -> con_valid, fifo_count, tx_count, halt, err all 0 immediately; new putchar accepted after release.

Source files
------------

// File: rtl/ecall_service_unit.sv
// ECALL service unit: handles halt/putchar system calls from the pipeline and streams
// console bytes through a first-word fall-through FIFO.
module ecall_service_unit #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [63:0]              req_a0,
  input  logic [63:0]              req_a1,
  output logic                     req_ready,
  output logic                     con_valid,
  output logic [7:0]               con_data,
  input  logic                     con_ready,
  output logic                     halt,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         tx_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StRun, StDrain, StHalted, StError} state_e;

  state_e           state_q, state_d;
  logic             halt_q, err_q;
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] tx_q;
  logic [7:0]       mem_q [DEPTH];

  logic accept, push, pop;

  assign req_ready  = (state_q == StRun) && (count_q < CW'(DEPTH));
  assign accept     = req_valid && req_ready;
  assign push       = accept && (req_a0 == 64'd1);
  assign con_valid  = (count_q != '0);
  assign pop        = con_valid && con_ready;
  assign con_data   = mem_q[rptr_q];
  assign fifo_count = count_q;
  assign tx_count   = tx_q;
  assign halt       = halt_q;
  assign err        = err_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (accept) begin
          if (req_a0 == 64'd0) begin
            state_d = StDrain;
          end else if (req_a0 != 64'd1) begin
            state_d = StError;
          end
        end
      end
      // Halt only once every buffered byte has left the FIFO.
      StDrain: if (count_q == '0) state_d = StHalted;
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= (state_d == StHalted);
      err_q   <= (state_d == StError);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      tx_q    <= '0;
    end else begin
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
        if (tx_q != '1) tx_q <= tx_q + CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= req_a1[7:0];
  end

endmodule

// File: tb/tb_ecall_service_unit.sv
// Directed bench for ecall_service_unit: console bytes are checked by a scoreboard monitor,
// control/status outputs by inline checks.
module tb_ecall_service_unit;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic [63:0]       req_a0 = '0;
  logic [63:0]       req_a1 = '0;
  logic              req_ready;
  logic              con_valid;
  logic [7:0]        con_data;
  logic              con_ready = 1'b0;
  logic              halt;
  logic              err;
  logic [3:0]        fifo_count;
  logic [CNT_W-1:0]  tx_count;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  ecall_service_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a0     (req_a0),
    .req_a1     (req_a1),
    .req_ready  (req_ready),
    .con_valid  (con_valid),
    .con_data   (con_data),
    .con_ready  (con_ready),
    .halt       (halt),
    .err        (err),
    .fifo_count (fifo_count),
    .tx_count   (tx_count)
  );

  always #5 clk = ~clk;

  // Monitor: every console handshake must match the oldest expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && con_valid && con_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL con_unexpected: got 0x%02h, expected no byte", con_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (con_data !== e) begin
            n_fail++;
            $display("FAIL con_data: got 0x%02h, expected 0x%02h", con_data, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  // Hold a request until accepted; queue the byte if it is a putchar.
  task automatic issue(input logic [63:0] a0, input logic [63:0] a1);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1;
    req_a0 = a0;
    req_a1 = a1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (req_ready) begin
        if (a0 == 64'd1) exp_q.push_back(a1[7:0]);
        ok = 1'b1;
      end
      tick();
    end
    req_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL issue_timeout: got req_ready=0, expected acceptance");
    end
  endtask

  task automatic wait_empty();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (fifo_count == 0) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got fifo_count=%0d, expected 0", fifo_count);
    end
  endtask

  initial begin
    // Reset values while reset is held
    #2;
    chk("rst_con_valid", con_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_halt", halt, 0);
    chk("rst_err", err, 0);
    chk("rst_req_ready", req_ready, 1);
    tick();
    rst = 1'b0;

    // Single putchar, upper a1 bits must be ignored
    con_ready = 1'b1;
    issue(64'd1, 64'hFFFF_FFFF_FFFF_FF41);
    chk("put_con_valid", con_valid, 1);
    chk("put_con_data", con_data, 8'h41);
    chk("put_fifo_count", fifo_count, 1);
    tick();
    chk("put_tx_count", tx_count, 1);
    chk("put_fifo_empty", fifo_count, 0);

    // Fill to DEPTH with sink stalled; ninth request waits for a pop
    con_ready = 1'b0;
    for (int i = 0; i < 8; i++) issue(64'd1, 64'(8'h30 + i));
    chk("full_count", fifo_count, 8);
    chk("full_req_ready", req_ready, 0);
    chk("full_head_stable", con_data, 8'h30);
    req_valid = 1'b1;
    req_a0 = 64'd1;
    req_a1 = 64'h38;
    tick();
    chk("full_ignored_count", fifo_count, 8);
    chk("full_head_held", con_data, 8'h30);
    con_ready = 1'b1;
    tick();
    con_ready = 1'b0;
    chk("after_pop_count", fifo_count, 7);
    chk("after_pop_ready", req_ready, 1);
    issue(64'd1, 64'h38);
    chk("refill_count", fifo_count, 8);
    con_ready = 1'b1;
    wait_empty();
    chk("fill_tx_count", tx_count, 10);

    // Halt with buffered bytes: drains first, halts the cycle after empty
    apply_reset();
    con_ready = 1'b0;
    issue(64'd1, 64'h61);
    issue(64'd1, 64'h62);
    issue(64'd1, 64'h63);
    issue(64'd0, 64'd0);
    chk("drain_halt0", halt, 0);
    chk("drain_req_ready", req_ready, 0);
    tick();
    chk("drain_stall_halt", halt, 0);
    chk("drain_stall_count", fifo_count, 3);
    con_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("drain_empty", fifo_count, 0);
    chk("drain_empty_halt", halt, 0);
    tick();
    chk("drain_halt1", halt, 1);
    chk("drain_tx_count", tx_count, 3);

    // Halt with empty FIFO, later requests ignored
    apply_reset();
    issue(64'd0, 64'd0);
    chk("eh_halt_drain", halt, 0);
    tick();
    chk("eh_halt", halt, 1);
    req_valid = 1'b1;
    req_a0 = 64'd1;
    req_a1 = 64'h77;
    tick();
    tick();
    req_valid = 1'b0;
    chk("eh_ignored_count", fifo_count, 0);
    chk("eh_ignored_valid", con_valid, 0);
    chk("eh_ready", req_ready, 0);
    chk("eh_still_halt", halt, 1);

    // Unsupported code: err sticky, buffered bytes still drained
    apply_reset();
    con_ready = 1'b0;
    issue(64'd1, 64'h71);
    issue(64'd1, 64'h72);
    issue(64'd2, 64'd0);
    chk("err_set", err, 1);
    chk("err_ready", req_ready, 0);
    chk("err_halt", halt, 0);
    chk("err_count", fifo_count, 2);
    con_ready = 1'b1;
    wait_empty();
    chk("err_tx_count", tx_count, 2);
    chk("err_sticky", err, 1);

    // All 64 bits of the service code are decoded
    apply_reset();
    issue(64'h1_0000_0001, 64'h55);
    chk("wide_err", err, 1);
    chk("wide_no_push", fifo_count, 0);

    // Asynchronous reset mid-drain
    apply_reset();
    con_ready = 1'b0;
    for (int i = 0; i < 5; i++) issue(64'd1, 64'(8'hA0 + i));
    issue(64'd0, 64'd0);
    con_ready = 1'b1;
    tick();
    chk("mid_count", fifo_count, 4);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_con_valid", con_valid, 0);
    chk("async_count", fifo_count, 0);
    chk("async_tx", tx_count, 0);
    chk("async_halt", halt, 0);
    chk("async_err", err, 0);
    #2;
    rst = 1'b0;
    tick();
    issue(64'd1, 64'h5A);
    wait_empty();
    chk("post_rst_tx", tx_count, 1);
    chk("post_rst_halt", halt, 0);

    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
